keccak_padder: RTL and testbench
================================

Name: keccak_padder

Overview:
- Upstream of the Keccak datapath input buffer; converts a raw byte-length message stream into rate-aligned, pad10*1-padded 64-bit words.
- Inserts the domain-suffix byte and the final 0x80 byte, emits zero fill words, and appends a whole padding block when the message ends on a block boundary.
- Flags each block boundary so the controller can trigger absorb after RATE_WORDS writes.

Parameters:
W, 64, lane/word width in bits; fixed at 64
RATE_WORDS, 17, words per rate block (1088-bit rate = 136 bytes)
LEN_WIDTH, 32, width of the message byte-length field

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches msg_bytes and suffix; ignored unless IDLE
msg_bytes  in  LEN_WIDTH  message length L in bytes
suffix  in  8  domain suffix byte (0x06 SHA3, 0x1F SHAKE)
in_valid  in  1  raw message word valid
in_ready  out  1  raw word accepted when in_valid & in_ready
in_data  in  W  raw word, little-endian bytes (byte k = bits 8k+7:8k)
out_valid  out  1  padded word valid
out_ready  in  1  downstream accepts (input buffer write enable = out_valid & out_ready)
out_data  out  W  padded word
out_block_last  out  1  current out word is word RATE_WORDS-1 of its block
out_msg_last  out  1  current out word is the final word of the final block
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final word transfers
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async): state IDLE; all counters 0; out_valid, in_ready, busy, done, err = 0; out_data = 0.
- On start: full_left = L>>3, tail = L[2:0], word_idx = 0. Next state: ABSORB if full_left>0; else TAIL if tail>0; else FILL.
- ABSORB: zero-latency pass-through. out_valid = in_valid; in_ready = out_ready; out_data = in_data, with bits 63:56 OR 0x80 when word_idx = RATE_WORDS-1. Each transfer decrements full_left and increments word_idx. When the transfer takes full_left to 0, next state is TAIL if tail>0, else FILL.
- TAIL: same handshake. out_data keeps bytes 0..tail-1 of in_data; byte tail = suffix; higher bytes = 0; byte 7 ORed with 0x80 if word_idx = RATE_WORDS-1. Next state is FILL, or IDLE if this word closed the block.
- FILL: in_ready = 0; out_valid = 1. out_data is built from registers only and is stable under backpressure:
  - byte 0 = suffix if the suffix is not yet emitted, else 0;
  - byte 7 ORed with 0x80 at word_idx = RATE_WORDS-1.
  - Leave FILL for IDLE after the transfer at word_idx = RATE_WORDS-1.
- word_idx wraps RATE_WORDS-1 -> 0 on transfer. out_block_last = (word_idx = RATE_WORDS-1) & out_valid. out_msg_last = out_block_last & the suffix has been emitted.
- Message ending on a block boundary (L mod 136 = 0, including L=0): an entire extra block is emitted: suffix at word 0 byte 0, 0x80 at word 16 byte 7.
- L mod 136 = 135: the last word is data bytes 0..6 plus byte 7 = suffix|0x80 (0x86 for SHA3). No extra block.
- done pulses in the cycle after the final transfer; the state is IDLE in that cycle. start in the same cycle as done is accepted.
- Backpressure: no state change and no counter update without a transfer. Upstream holds in_data stable while in_valid & !in_ready.
- A reset asserted mid-message aborts immediately to IDLE. Partial output is discarded by the datapath's own reset.

Optional Feature:
- Macro KECCAK_PADDER_ERR_EN.
- Defined: err is set and held until rst when either of these occurs:
  - in_valid = 1 while in IDLE or FILL (excess input data);
  - start = 1 while busy.
  The offending word or start is otherwise ignored.
- Undefined: err tied to 0 and no detection logic is built. All other behaviour is identical.

Test Plan:
- L=0, suffix=0x06: 17 out words, no in_ready. Word0 = 0x0000000000000006; words 1..15 = 0; word16 = 0x8000000000000000 with out_block_last = out_msg_last = 1; done one cycle later.
- L=3, in_data=0xFFFFFFFFFFCCBBAA, suffix=0x1F: word0 = 0x000000001FCCBBAA, words 1..15 = 0, word16 = 0x8000000000000000.
- L=135, 17 input words of all-ones, suffix=0x06: words 0..15 pass unchanged; word16 = 0x86FFFFFFFFFFFFFF; exactly 17 outputs.
- L=136, 17 all-ones words: 17 pass-through words (word16 = 0xFFFF...FF, since 0x80 is already set by OR) with out_block_last on word16 and out_msg_last=0; then 17 pad words: 0x06, 0 x15, 0x8000000000000000 with out_msg_last=1.
- L=16, out_ready toggled 1,0,0,1 and in_valid gaps: no duplicated or dropped words; out_data stable while stalled in FILL; exactly 17 transfers total.
- Assert rst during FILL at word 5: next cycle IDLE, busy=0, out_valid=0. With KECCAK_PADDER_ERR_EN, an in_valid pulse in IDLE sets err=1 and err stays 1 until rst.

Source files
------------

// File: rtl/keccak_padder_if.sv
// keccak_padder_if: handshake and control bundle between the message source,
// the padder and the Keccak input buffer.
// master: the side driving the raw message and control (source/controller).
// slave : the padder itself.
interface keccak_padder_if #(
  parameter int W         = 64,
  parameter int LEN_WIDTH = 32
);
  logic                 start;
  logic [LEN_WIDTH-1:0] msg_bytes;
  logic [7:0]           suffix;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic                 out_block_last;
  logic                 out_msg_last;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, msg_bytes, suffix, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_block_last, out_msg_last,
           busy, done, err
  );

  modport slave (
    input  start, msg_bytes, suffix, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_block_last, out_msg_last,
           busy, done, err
  );
endinterface

// File: rtl/keccak_padder.sv
// keccak_padder: turns a byte-length message stream into rate-aligned,
// pad10*1-padded 64-bit words for the Keccak input buffer.
//
// Optional feature macro: KECCAK_PADDER_ERR_EN
//   defined   -> sticky err flag for excess input words or start while busy
//   undefined -> err tied low, no detection logic
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// ABSORB | full 8-byte message words pass straight through
// TAIL   | last partial word: kept bytes, suffix byte, zeros above
// FILL   | register-only zero words until the rate block closes
module keccak_padder #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 17,
  parameter int LEN_WIDTH  = 32
) (
  input logic            clk,
  input logic            rst,
  keccak_padder_if.slave bus
);

  localparam int NB    = W / 8;
  localparam int IDX_W = $clog2(RATE_WORDS);
  localparam int CNT_W = LEN_WIDTH - 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ABSORB,
    S_TAIL,
    S_FILL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] full_left_q, full_left_d;
  logic [2:0]       tail_q, tail_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [7:0]       suffix_q, suffix_d;
  logic             sfx_sent_q, sfx_sent_d;
  logic             done_q, done_d;

  logic             out_valid_c;
  logic             in_ready_c;
  logic [W-1:0]     out_data_c;
  logic [W-1:0]     tail_word;
  logic             blk_end;
  logic             xfer;
  logic [IDX_W-1:0] next_idx;

  assign blk_end  = (word_idx_q == LAST_IDX);
  assign xfer     = out_valid_c & bus.out_ready;
  assign next_idx = blk_end ? '0 : word_idx_q + IDX_W'(1);

  // Partial word: message bytes below tail, suffix at byte tail, zeros above.
  always_comb begin
    tail_word = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < int'(tail_q)) begin
        tail_word[8*k +: 8] = bus.in_data[8*k +: 8];
      end else if (k == int'(tail_q)) begin
        tail_word[8*k +: 8] = suffix_q;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      full_left_q <= '0;
      tail_q      <= '0;
      word_idx_q  <= '0;
      suffix_q    <= '0;
      sfx_sent_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_left_q <= full_left_d;
      tail_q      <= tail_d;
      word_idx_q  <= word_idx_d;
      suffix_q    <= suffix_d;
      sfx_sent_q  <= sfx_sent_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter updates and output word formation.
  always_comb begin
    state_d     = state_q;
    full_left_d = full_left_q;
    tail_d      = tail_q;
    word_idx_d  = word_idx_q;
    suffix_d    = suffix_q;
    sfx_sent_d  = sfx_sent_q;
    done_d      = 1'b0;
    out_valid_c = 1'b0;
    in_ready_c  = 1'b0;
    out_data_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          full_left_d = bus.msg_bytes[LEN_WIDTH-1:3];
          tail_d      = bus.msg_bytes[2:0];
          word_idx_d  = '0;
          suffix_d    = bus.suffix;
          sfx_sent_d  = 1'b0;
          if (bus.msg_bytes[LEN_WIDTH-1:3] != '0) begin
            state_d = S_ABSORB;
          end else if (bus.msg_bytes[2:0] != 3'd0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_ABSORB: begin
        out_valid_c = bus.in_valid;
        in_ready_c  = bus.out_ready;
        out_data_c  = bus.in_data;
        if (blk_end) begin
          out_data_c[W-1 -: 8] = out_data_c[W-1 -: 8] | 8'h80;
        end
        if (xfer) begin
          full_left_d = full_left_q - CNT_W'(1);
          word_idx_d  = next_idx;
          if (full_left_q == CNT_W'(1)) begin
            state_d = (tail_q != 3'd0) ? S_TAIL : S_FILL;
          end
        end
      end

      S_TAIL: begin
        out_valid_c = bus.in_valid;
        in_ready_c  = bus.out_ready;
        out_data_c  = tail_word;
        if (blk_end) begin
          out_data_c[W-1 -: 8] = out_data_c[W-1 -: 8] | 8'h80;
        end
        if (xfer) begin
          word_idx_d = next_idx;
          sfx_sent_d = 1'b1;
          if (blk_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        out_valid_c = 1'b1;
        if (!sfx_sent_q) begin
          out_data_c[7:0] = suffix_q;
        end
        if (blk_end) begin
          out_data_c[W-1 -: 8] = out_data_c[W-1 -: 8] | 8'h80;
        end
        if (xfer) begin
          word_idx_d = next_idx;
          sfx_sent_d = 1'b1;
          if (blk_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_valid      = out_valid_c;
  assign bus.in_ready       = in_ready_c;
  assign bus.out_data       = out_data_c;
  assign bus.out_block_last = blk_end & out_valid_c;
  // The suffix is out once past ABSORB: TAIL and the first FILL word carry it.
  assign bus.out_msg_last   = blk_end & out_valid_c &
                              (sfx_sent_q | (state_q == S_TAIL) | (state_q == S_FILL));
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = done_q;

`ifdef KECCAK_PADDER_ERR_EN
  logic err_q;

  // Sticky protocol error: surplus input words, or start while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((bus.in_valid && (state_q == S_IDLE || state_q == S_FILL)) ||
                 (bus.start && state_q != S_IDLE)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: padded-byte model, random traffic.
module tb_keccak_padder;

  logic clk = 1'b0;
  logic rst;

  keccak_padder_if #(.W(64), .LEN_WIDTH(32)) bus ();

  keccak_padder #(.W(64), .RATE_WORDS(17), .LEN_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        bl;
    logic        ml;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  exp_t        exp_q[$];
  logic [63:0] msg_w[$];
  bit          chk_en = 1'b0;
  bit          exp_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Padded message = message bytes, suffix, zeros to a 136-byte multiple, last
  // byte |= 0x80. Every word at block position 16 also gets 0x80 in its top byte.
  task automatic build_model(input int len, input logic [7:0] sfx);
    int          total;
    logic [7:0]  pb[];
    logic [63:0] w;
    exp_t        e;
    total = ((len + 136) / 136) * 136;
    pb = new[total];
    for (int b = 0; b < total; b++) begin
      if (b < len) begin
        w = msg_w[b / 8];
        pb[b] = w[(b % 8) * 8 +: 8];
      end else if (b == len) begin
        pb[b] = sfx;
      end else begin
        pb[b] = 8'h00;
      end
    end
    pb[total - 1] = pb[total - 1] | 8'h80;
    exp_q.delete();
    for (int i = 0; i < total / 8; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[k * 8 +: 8] = pb[i * 8 + k];
      if (i % 17 == 16) w[63:56] = w[63:56] | 8'h80;
      e.d  = w;
      e.bl = (i % 17 == 16);
      e.ml = (i == total / 8 - 1);
      exp_q.push_back(e);
    end
  endtask

  // kind: 0 random words, 1 all-ones, 2 word0 = custom
  task automatic prep(input int len, input logic [7:0] sfx, input int kind,
                      input logic [63:0] custom);
    int nw;
    nw = (len + 7) / 8;
    msg_w.delete();
    for (int i = 0; i < nw; i++) begin
      if (kind == 1)                msg_w.push_back('1);
      else if (kind == 2 && i == 0) msg_w.push_back(custom);
      else                          msg_w.push_back({$urandom, $urandom});
    end
    build_model(len, sfx);
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random. gap: random in_valid gaps.
  task automatic run_msg(input int len, input logic [7:0] sfx, input int rmode, input bit gap);
    int         nw, idx, cyc, base;
    bit         acc;
    logic [3:0] pat;
    pat  = 4'b1001;
    nw   = (len + 7) / 8;
    idx  = 0;
    cyc  = 0;
    acc  = 1'b0;
    base = done_cnt;
    @(posedge clk); #1;
    bus.msg_bytes = len;
    bus.suffix    = sfx;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (done_cnt == base && cyc < 3000) begin
      if (acc) bus.in_valid = 1'b0;
      acc = 1'b0;
      if (!bus.in_valid && idx < nw && (!gap || $urandom_range(3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg_w[idx];
      end
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[3 - (cyc % 4)];
        default: bus.out_ready = ($urandom_range(2) != 0);
      endcase
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (acc) bus.in_valid = 1'b0;
    chk("txn_complete", 64'(done_cnt != base), 64'd1);
    chk("inputs_consumed", 64'(idx), 64'(nw));
    chk("expected_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_after_done", 64'(bus.busy), 64'd0);
  endtask

  // Compare process: outputs against the model front on every valid cycle.
  always @(negedge clk) begin : cmp
    exp_t e;
    bit   nd;
    if (chk_en && !rst) begin
      nd = 1'b0;
      chk("done", 64'(bus.done), 64'(exp_done));
      if (exp_done) done_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          chk("out_data", bus.out_data, e.d);
          chk("out_block_last", 64'(bus.out_block_last), 64'(e.bl));
          chk("out_msg_last", 64'(bus.out_msg_last), 64'(e.ml));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            nd = e.ml;
          end
        end
      end else begin
        chk("block_last_quiet", 64'(bus.out_block_last), 64'd0);
      end
`ifndef KECCAK_PADDER_ERR_EN
      chk("err_tied_low", 64'(bus.err), 64'd0);
`endif
      exp_done = nd;
    end
  end

  initial begin
    int   len, cnt;
    logic [7:0] sfx;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.msg_bytes = '0;
    bus.suffix    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // L=0, SHA3 suffix: one whole pad block.
    prep(0, 8'h06, 0, '0);
    chk("model_L0_size", 64'(exp_q.size()), 64'd17);
    chk("model_L0_w0", exp_q[0].d, 64'h0000000000000006);
    chk("model_L0_w16", exp_q[16].d, 64'h8000000000000000);
    run_msg(0, 8'h06, 0, 1'b0);

    // L=3, SHAKE suffix.
    prep(3, 8'h1F, 2, 64'hFFFFFFFFFFCCBBAA);
    chk("model_L3_w0", exp_q[0].d, 64'h000000001FCCBBAA);
    run_msg(3, 8'h1F, 0, 1'b0);

    // L=135: suffix shares the final byte with 0x80.
    prep(135, 8'h06, 1, '0);
    chk("model_L135_size", 64'(exp_q.size()), 64'd17);
    chk("model_L135_w16", exp_q[16].d, 64'h86FFFFFFFFFFFFFF);
    run_msg(135, 8'h06, 0, 1'b1);

    // L=136: message fills a block, extra pad block follows.
    prep(136, 8'h06, 1, '0);
    chk("model_L136_size", 64'(exp_q.size()), 64'd34);
    chk("model_L136_w16_ml", 64'(exp_q[16].ml), 64'd0);
    chk("model_L136_w17", exp_q[17].d, 64'h0000000000000006);
    run_msg(136, 8'h06, 2, 1'b1);

    // L=16 with out_ready 1,0,0,1 and input gaps.
    prep(16, 8'h06, 0, '0);
    run_msg(16, 8'h06, 1, 1'b1);

    // Randomized lengths, suffixes and backpressure.
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 420);
      case ($urandom_range(2))
        0:       sfx = 8'h06;
        1:       sfx = 8'h1F;
        default: sfx = 8'($urandom_range(1, 127));
      endcase
      prep(len, sfx, 0, '0);
      run_msg(len, sfx, $urandom_range(2), 1'($urandom_range(1)));
    end

    // Reset asserted while in FILL at word 5.
    chk_en = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.msg_bytes = 0;
    bus.suffix    = 8'h06;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) cnt++;
    end
    @(negedge clk);
    chk("fill_word5_reached", 64'(cnt), 64'd5);
    chk("fill_word5_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_abort_busy", 64'(bus.busy), 64'd0);
    chk("after_abort_block_last", 64'(bus.out_block_last), 64'd0);

`ifdef KECCAK_PADDER_ERR_EN
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(bus.err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(bus.err), 64'd1);
    rst = 1'b1;
    #1;
    chk("err_cleared", 64'(bus.err), 64'd0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
